// File: rtl/srt4_pkg.sv
// Purpose: shared encodings for the radix-4 SRT divider controller: FSM states,
//          quotient-digit codes and a digit-legality helper.
// Latency: n/a (types and constants only). Backpressure: n/a.
package srt4_pkg;

  // Controller schedule.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    CORR = 3'd3,
    DONE = 3'd4
  } state_t;

  // Quotient-digit encodings produced by the selection logic.
  localparam logic [2:0] Q_ZERO = 3'b000;
  localparam logic [2:0] Q_P1   = 3'b001;
  localparam logic [2:0] Q_P2   = 3'b010;
  localparam logic [2:0] Q_M1   = 3'b110;
  localparam logic [2:0] Q_M2   = 3'b101;

  // Legal codes are the five digits above; 011/100/111 are illegal.
  function automatic logic digit_legal(input logic [2:0] d);
    return (d == Q_ZERO) || (d == Q_P1) || (d == Q_P2) ||
           (d == Q_M1)   || (d == Q_M2);
  endfunction

endpackage

// File: rtl/srt4_otf_conv.sv
// Purpose: on-the-fly conversion of signed radix-4 digits into Q and QM = Q-1.
// Latency: one digit folded per enabled cycle; outputs are the registers.
// Backpressure: none; en qualifies each digit, clr wins over en.
// Ports: clk, rst (async, active high), clr (zero Q/QM), en (digit valid),
//        q_digit (3-bit code), q / qm (QW-bit converted quotient and quotient-1).
module srt4_otf_conv
  import srt4_pkg::*;
#(
  parameter int QW = 24  // must be >= 4 (at least two digits)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [2:0]    q_digit,
  output logic [QW-1:0] q,
  output logic [QW-1:0] qm
);

  logic [QW-1:0] q_q, q_d;
  logic [QW-1:0] qm_q, qm_d;

  // Each new digit either extends Q (non-negative digits) or borrows from QM
  // (negative digits), so no carry ever has to ripple through the result.
  always_comb begin
    q_d  = q_q;
    qm_d = qm_q;
    if (clr) begin
      q_d  = '0;
      qm_d = '0;
    end else if (en) begin
      case (q_digit)
        Q_P1: begin
          q_d  = {q_q[QW-3:0], 2'd1};
          qm_d = {q_q[QW-3:0], 2'd0};
        end
        Q_P2: begin
          q_d  = {q_q[QW-3:0], 2'd2};
          qm_d = {q_q[QW-3:0], 2'd1};
        end
        Q_M1: begin
          q_d  = {qm_q[QW-3:0], 2'd3};
          qm_d = {qm_q[QW-3:0], 2'd2};
        end
        Q_M2: begin
          q_d  = {qm_q[QW-3:0], 2'd2};
          qm_d = {qm_q[QW-3:0], 2'd1};
        end
        // Zero digit; illegal codes are folded in as zero.
        default: begin
          q_d  = {q_q[QW-3:0], 2'd0};
          qm_d = {qm_q[QW-3:0], 2'd3};
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q  <= '0;
      qm_q <= '0;
    end else begin
      q_q  <= q_d;
      qm_q <= qm_d;
    end
  end

  assign q  = q_q;
  assign qm = qm_q;

endmodule

// File: rtl/srt4_div_ctrl.sv
// Purpose: sequencer for the radix-4 SRT divider (IDLE->LOAD->ITER->CORR->DONE).
// Latency: start at edge t -> done after edge t+ITERS+3 (t+2 on divide-by-zero).
// Backpressure: start is accepted only in IDLE; requests while busy are dropped.
// Ports: clk, rst (async, active high), start, div_zero, q_digit, rem_neg in;
//        busy, ld_operands, rem_en, q_sel, corr_en, done strobes out;
//        quo / dz result and sticky bad_digit status out.
module srt4_div_ctrl
  import srt4_pkg::*;
#(
  parameter  int ITERS = 12,       // must be >= 2
  localparam int QW    = 2 * ITERS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          div_zero,
  input  logic [2:0]    q_digit,
  input  logic          rem_neg,
  output logic          busy,
  output logic          ld_operands,
  output logic          rem_en,
  output logic [2:0]    q_sel,
  output logic          corr_en,
  output logic          done,
  output logic [QW-1:0] quo,
  output logic          dz,
  output logic          bad_digit
);

  localparam int            CW   = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  state_t        state_q, state_d;
  logic          start_q, start_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] quo_q, quo_d;
  logic          dz_q, dz_d;
  logic          bad_q, bad_d;
  logic          accept;
  logic [QW-1:0] otf_q, otf_qm;

  // start is registered so nothing downstream sees it combinationally. Only a
  // request seen while IDLE is captured; the !start_q term stops a held start
  // from re-arming on the cycle it is being consumed.
  assign start_d = (state_q == IDLE) && start && !start_q;
  assign accept  = (state_q == IDLE) && start_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_q) state_d = LOAD;
      LOAD:    state_d = div_zero ? DONE : ITER;
      ITER:    if (cnt_q == LAST) state_d = CORR;
      CORR:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    busy        = (state_q != IDLE);
    ld_operands = (state_q == LOAD);
    rem_en      = (state_q == ITER);
    q_sel       = (state_q == ITER) ? q_digit : Q_ZERO;
    corr_en     = (state_q == CORR) && rem_neg;
    done        = (state_q == DONE);
  end

  // Counter, result and status next values.
  always_comb begin
    cnt_d = cnt_q;
    quo_d = quo_q;
    dz_d  = dz_q;
    bad_d = bad_q;
    if (accept) begin
      cnt_d = '0;
      bad_d = 1'b0;
    end
    if (state_q == ITER) begin
      cnt_d = cnt_q + 1'b1;
      if (!digit_legal(q_digit)) bad_d = 1'b1;
    end
    if (state_q == LOAD && div_zero) begin
      quo_d = '1;
      dz_d  = 1'b1;
    end
    // Negative final remainder means the last digit overshot by one: use Q-1.
    if (state_q == CORR) begin
      quo_d = rem_neg ? otf_qm : otf_q;
      dz_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      cnt_q   <= '0;
      quo_q   <= '0;
      dz_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      dz_q    <= dz_d;
      bad_q   <= bad_d;
    end
  end

  assign quo       = quo_q;
  assign dz        = dz_q;
  assign bad_digit = bad_q;

  srt4_otf_conv #(.QW(QW)) u_otf (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (state_q == ITER),
    .q_digit (q_digit),
    .q       (otf_q),
    .qm      (otf_qm)
  );

endmodule

// File: tb/tb_srt4_div_ctrl.sv
// Purpose: self-checking bench for srt4_div_ctrl (ITERS=2 and ITERS=3 instances).
// Latency: n/a. Backpressure: n/a.
module tb_srt4_div_ctrl;
  import srt4_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, div_zero, rem_neg;
  logic [2:0] q_digit;
  logic busy, ld_operands, rem_en, corr_en, done, dz, bad_digit;
  logic [2:0] q_sel;
  logic [3:0] quo;

  logic start3, div_zero3, rem_neg3;
  logic [2:0] q_digit3;
  logic busy3, ld_operands3, rem_en3, corr_en3, done3, dz3, bad_digit3;
  logic [2:0] q_sel3;
  logic [5:0] quo3;

  srt4_div_ctrl #(.ITERS(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .div_zero(div_zero), .q_digit(q_digit),
    .rem_neg(rem_neg), .busy(busy), .ld_operands(ld_operands), .rem_en(rem_en),
    .q_sel(q_sel), .corr_en(corr_en), .done(done), .quo(quo), .dz(dz),
    .bad_digit(bad_digit)
  );

  srt4_div_ctrl #(.ITERS(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .div_zero(div_zero3), .q_digit(q_digit3),
    .rem_neg(rem_neg3), .busy(busy3), .ld_operands(ld_operands3), .rem_en(rem_en3),
    .q_sel(q_sel3), .corr_en(corr_en3), .done(done3), .quo(quo3), .dz(dz3),
    .bad_digit(bad_digit3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] d0;
    logic [2:0] d1;
    logic       rn;
    logic       dzi;
    logic [3:0] quo;
    logic       dzo;
    logic       bad;
  } vec_t;

  vec_t vt[9];

  // One divide on the ITERS=2 instance; digits are supplied while rem_en is high.
  task automatic run2(input logic [2:0] d0, input logic [2:0] d1, input logic rn,
                      input logic dzi, output int lat, output int n_rem,
                      output int n_corr, output int n_ld, output int qsel_bad);
    logic [2:0] dig [2];
    int di;
    logic in_iter;
    dig[0] = d0;
    dig[1] = d1;
    di = 0;
    lat = -1; n_rem = 0; n_corr = 0; n_ld = 0; qsel_bad = 0;
    @(posedge clk); #1;
    start = 1'b1; rem_neg = rn; div_zero = dzi; q_digit = Q_ZERO;
    @(posedge clk); #1;   // start sampled at this edge
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      in_iter = rem_en;
      if (in_iter) begin
        q_digit = (di < 2) ? dig[di] : Q_ZERO;
        di++;
        n_rem++;
      end
      #1;
      if (q_sel !== (in_iter ? q_digit : 3'b000)) qsel_bad++;
      if (ld_operands) n_ld++;
      if (corr_en) n_corr++;
      if (done) begin
        lat = k;
        break;
      end
    end
    q_digit = Q_ZERO;
  endtask

  initial begin
    int lat, nr, nc, nl, qb;
    logic [3:0] held;
    logic [2:0] d3 [3];
    int di, lat3, guard;
    logic seen_busy;

    //           d0      d1      rn    dzi   quo      dzo   bad
    vt[0] = '{Q_P1,   Q_M2,   1'b0, 1'b0, 4'b0010, 1'b0, 1'b0};
    vt[1] = '{Q_P1,   Q_M2,   1'b1, 1'b0, 4'b0001, 1'b0, 1'b0};
    vt[2] = '{Q_P2,   Q_P2,   1'b0, 1'b0, 4'b1010, 1'b0, 1'b0};
    vt[3] = '{Q_P2,   Q_P2,   1'b1, 1'b0, 4'b1001, 1'b0, 1'b0};
    vt[4] = '{Q_M1,   Q_M1,   1'b0, 1'b0, 4'b1011, 1'b0, 1'b0};
    vt[5] = '{Q_ZERO, Q_ZERO, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0};
    vt[6] = '{3'b011, Q_P1,   1'b0, 1'b0, 4'b0001, 1'b0, 1'b1};
    vt[7] = '{Q_P1,   Q_P1,   1'b0, 1'b1, 4'b1111, 1'b1, 1'b0};
    vt[8] = '{Q_P1,   Q_P1,   1'b0, 1'b0, 4'b0101, 1'b0, 1'b0};
    d3[0] = Q_P2; d3[1] = Q_ZERO; d3[2] = Q_M1;

    rst = 1'b1; start = 1'b0; div_zero = 1'b0; rem_neg = 1'b0; q_digit = Q_ZERO;
    start3 = 1'b0; div_zero3 = 1'b0; rem_neg3 = 1'b0; q_digit3 = Q_ZERO;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs_u2", {busy, ld_operands, rem_en, q_sel, corr_en, done, quo, dz, bad_digit}, 0);
    check("reset_outs_u3", {busy3, ld_operands3, rem_en3, q_sel3, corr_en3, done3, quo3, dz3, bad_digit3}, 0);
    check("reset_qqm_u3", {u3.u_otf.q, u3.u_otf.qm}, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run2(vt[i].d0, vt[i].d1, vt[i].rn, vt[i].dzi, lat, nr, nc, nl, qb);
      check($sformatf("v%0d_latency", i), lat, vt[i].dzi ? 2 : 5);
      check($sformatf("v%0d_quo", i), quo, vt[i].quo);
      check($sformatf("v%0d_dz", i), dz, vt[i].dzo);
      check($sformatf("v%0d_bad_digit", i), bad_digit, vt[i].bad);
      check($sformatf("v%0d_rem_en_cycles", i), nr, vt[i].dzi ? 0 : 2);
      check($sformatf("v%0d_corr_en_cycles", i), nc, (vt[i].rn && !vt[i].dzi) ? 1 : 0);
      check($sformatf("v%0d_ld_cycles", i), nl, 1);
      check($sformatf("v%0d_q_sel_errs", i), qb, 0);
      held = quo;
      @(posedge clk); #1;
      check($sformatf("v%0d_done_one_cycle", i), {done, busy}, 0);
      check($sformatf("v%0d_quo_held", i), quo, vt[i].quo);
      check($sformatf("v%0d_quo_stable", i), quo, held);
    end

    // start pulsed during ITER and during DONE must be dropped.
    @(posedge clk); #1;
    start = 1'b1; rem_neg = 1'b0; div_zero = 1'b0; q_digit = Q_P1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!rem_en && guard < 20) begin @(posedge clk); #1; guard++; end
    check("ign_reach_iter", rem_en, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!done && guard < 20) begin @(posedge clk); #1; guard++; end
    check("ign_reach_done", done, 1);
    check("ign_quo", quo, 4'b0101);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen_busy = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy) seen_busy = 1'b1;
    end
    check("ign_no_restart", seen_busy, 0);

    // Reset in the middle of ITER returns everything to zero immediately.
    start = 1'b1; q_digit = 3'b111;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!rem_en && guard < 20) begin @(posedge clk); #1; guard++; end
    check("rst_reach_iter", rem_en, 1);
    @(posedge clk); #1;  // illegal digit folded in, bad_digit now set
    rst = 1'b1;
    #1;
    check("rst_async_outs", {busy, ld_operands, rem_en, q_sel, corr_en, done, quo, dz, bad_digit}, 0);
    @(posedge clk); #1;
    check("rst_next_cycle_outs", {busy, ld_operands, rem_en, q_sel, corr_en, done, quo, dz, bad_digit}, 0);
    rst = 1'b0; q_digit = Q_ZERO;

    // ITERS=3: digits +2, 0, -1.
    @(posedge clk); #1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    di = 0; lat3 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (rem_en3) begin
        q_digit3 = (di < 3) ? d3[di] : Q_ZERO;
        di++;
      end
      if (done3) begin
        lat3 = k;
        break;
      end
    end
    check("it3_latency", lat3, 6);
    check("it3_quo", quo3, 6'b011111);
    check("it3_qm", u3.u_otf.qm, 6'b011110);
    check("it3_dz_bad", {dz3, bad_digit3}, 0);
    check("it3_digits_taken", di, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
